// File: rtl/sram_1rw1r_param.sv
// sram_1rw1r_param: parametrised 1RW+1R SRAM with post-reset clear sweep, read-valid strobes and collision counting
module sram_1rw1r_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int BYTE_WIDTH = 8,
  parameter int READ_LAT = 1,
  parameter int BYPASS = 1,
  parameter int CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
  parameter int CNT_WIDTH = 16,
  localparam int RAM_DEPTH = 1 << ADDR_WIDTH,
  localparam int NUM_WMASKS = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_valid,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  init_done,
  output logic [CNT_WIDTH-1:0]  collision_cnt
);
  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_byte_width
    $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_read_lat
    $error("READ_LAT must be 1 or 2");
  end

  typedef enum logic {CLEAR, READY} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] lane_mask, old0, merged, rd1_data, p0_d, p1_d, o0_d, o1_d;
  logic clr_en, wr_en, rd0, rd1, coll, p0_v, p1_v, o0_v, o1_v;

  for (genvar i = 0; i < NUM_WMASKS; i++) begin : g_lane
    assign lane_mask[i*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{wmask0[i]}};
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      ptr <= '0;
    end else begin
      state <= state_nx;
      ptr <= clr_en ? ptr + ADDR_WIDTH'(1) : ptr;
    end
  end

  always_comb state_nx = (state == CLEAR && &ptr) ? READY : state;

  always_comb begin
    init_done = state == READY;
    clr_en = state == CLEAR;
  end

  // Requests only act once the sweep is finished and reset is released
  always_comb begin
    wr_en = init_done && rstb && !csb0 && !web0;
    rd0 = init_done && rstb && !csb0 && web0;
    rd1 = init_done && rstb && !csb1;
    coll = wr_en && rd1 && addr0 == addr1;
    old0 = mem[addr0];
    merged = (din0 & lane_mask) | (old0 & ~lane_mask);
    rd1_data = (BYPASS != 0 && coll) ? merged : mem[addr1];
    o0_v = (READ_LAT == 1) ? rd0 : p0_v;
    o0_d = (READ_LAT == 1) ? old0 : p0_d;
    o1_v = (READ_LAT == 1) ? rd1 : p1_v;
    o1_d = (READ_LAT == 1) ? rd1_data : p1_d;
  end

  always_ff @(posedge clk) begin
    if (clr_en)
      mem[ptr] <= CLEAR_VALUE;
    else if (wr_en)
      mem[addr0] <= merged;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      p0_v <= 1'b0;
      p1_v <= 1'b0;
      p0_d <= '0;
      p1_d <= '0;
      dout0 <= '0;
      dout1 <= '0;
      dout0_valid <= 1'b0;
      dout1_valid <= 1'b0;
      collision_cnt <= '0;
    end else begin
      p0_v <= rd0;
      p1_v <= rd1;
      p0_d <= old0;
      p1_d <= rd1_data;
      dout0_valid <= o0_v;
      dout1_valid <= o1_v;
      dout0 <= o0_v ? o0_d : dout0;
      dout1 <= o1_v ? o1_d : dout1;
      collision_cnt <= (coll && !(&collision_cnt)) ? collision_cnt + CNT_WIDTH'(1) : collision_cnt;
    end
  end
endmodule

// File: tb/tb_sram_1rw1r_param.sv
// tb_sram_1rw1r_param: scoreboard bench driving a default instance and a READ_LAT=2/BYPASS=0/CNT_WIDTH=2 instance in lockstep
module tb_sram_1rw1r_param;
  logic clk = 1'b0;
  logic rstb, csb0, web0, csb1;
  logic [3:0] wmask0;
  logic [6:0] addr0, addr1;
  logic [31:0] din0;
  logic [31:0] dout0_a, dout1_a, dout0_b, dout1_b;
  logic dout0_valid_a, dout1_valid_a, dout0_valid_b, dout1_valid_b, init_done_a, init_done_b;
  logic [15:0] cnt_a;
  logic [1:0] cnt_b;
  int checks = 0;
  int failures = 0;
  logic [31:0] ref_mem [128];
  logic [31:0] qa0[$], qa1[$], qb0[$], qb1[$];
  logic [31:0] e;

  always #5 clk = ~clk;

  sram_1rw1r_param dut_a (
    .clk(clk), .rstb(rstb), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(dout0_a), .dout0_valid(dout0_valid_a), .csb1(csb1), .addr1(addr1), .dout1(dout1_a),
    .dout1_valid(dout1_valid_a), .init_done(init_done_a), .collision_cnt(cnt_a)
  );

  sram_1rw1r_param #(.READ_LAT(2), .BYPASS(0), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rstb(rstb), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(dout0_b), .dout0_valid(dout0_valid_b), .csb1(csb1), .addr1(addr1), .dout1(dout1_b),
    .dout1_valid(dout1_valid_b), .init_done(init_done_b), .collision_cnt(cnt_b)
  );

  always @(negedge clk) begin
    if (dout0_valid_a) begin
      checks++;
      e = (qa0.size() != 0) ? qa0.pop_front() : 32'hxxxx_xxxx;
      if (dout0_a !== e) begin failures++; $display("FAIL a_dout0 got=%h exp=%h", dout0_a, e); end
    end
    if (dout1_valid_a) begin
      checks++;
      e = (qa1.size() != 0) ? qa1.pop_front() : 32'hxxxx_xxxx;
      if (dout1_a !== e) begin failures++; $display("FAIL a_dout1 got=%h exp=%h", dout1_a, e); end
    end
    if (dout0_valid_b) begin
      checks++;
      e = (qb0.size() != 0) ? qb0.pop_front() : 32'hxxxx_xxxx;
      if (dout0_b !== e) begin failures++; $display("FAIL b_dout0 got=%h exp=%h", dout0_b, e); end
    end
    if (dout1_valid_b) begin
      checks++;
      e = (qb1.size() != 0) ? qb1.pop_front() : 32'hxxxx_xxxx;
      if (dout1_b !== e) begin failures++; $display("FAIL b_dout1 got=%h exp=%h", dout1_b, e); end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csb0 = 1'b1;
    web0 = 1'b1;
    csb1 = 1'b1;
    wmask0 = '0;
    addr0 = '0;
    addr1 = '0;
    din0 = '0;
  endtask

  task automatic drive(input bit w, input logic [6:0] a0, input logic [31:0] d, input logic [3:0] m,
                       input bit r0, input bit r1, input logic [6:0] a1);
    logic [31:0] mg;
    mg = ref_mem[a0];
    for (int i = 0; i < 4; i++) if (m[i]) mg[i*8 +: 8] = d[i*8 +: 8];
    csb0 = !(w || r0);
    web0 = !w;
    wmask0 = m;
    addr0 = a0;
    din0 = d;
    csb1 = !r1;
    addr1 = a1;
    if (r0) begin qa0.push_back(ref_mem[a0]); qb0.push_back(ref_mem[a0]); end
    if (r1) begin
      qa1.push_back((w && a0 == a1) ? mg : ref_mem[a1]);
      qb1.push_back(ref_mem[a1]);
    end
    if (w) ref_mem[a0] = mg;
    tick();
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 8 && (qa0.size() + qa1.size() + qb0.size() + qb1.size()) != 0; i++) tick();
    checks++;
    if ((qa0.size() + qa1.size() + qb0.size() + qb1.size()) != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", qa0.size() + qa1.size() + qb0.size() + qb1.size());
      qa0.delete(); qa1.delete(); qb0.delete(); qb1.delete();
    end
    tick();
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    idle();
    repeat (3) tick();
    checks++;
    if ({dout0_a, dout1_a, dout0_b, dout1_b, cnt_a, cnt_b} !== '0 ||
        {dout0_valid_a, dout1_valid_a, dout0_valid_b, dout1_valid_b, init_done_a, init_done_b} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h/%h cnt=%h init=%b%b exp=0", dout0_a, dout1_b, cnt_a, init_done_a, init_done_b);
    end
    rstb = 1'b1;
    repeat (10) tick();
    csb0 = 1'b0; web0 = 1'b0; addr0 = 7'd0; din0 = 32'hFFFF_FFFF; wmask0 = 4'hF; csb1 = 1'b0; addr1 = 7'd3;
    tick();
    web0 = 1'b1;
    tick();
    idle();
    repeat (115) tick();
    checks++;
    if (init_done_a !== 1'b0 || init_done_b !== 1'b0) begin
      failures++;
      $display("FAIL init_early got=%b%b exp=00", init_done_a, init_done_b);
    end
    tick();
    checks++;
    if (init_done_a !== 1'b1 || init_done_b !== 1'b1) begin
      failures++;
      $display("FAIL init_128 got=%b%b exp=11", init_done_a, init_done_b);
    end
  endtask

  task automatic test_cleared_read();
    drive(0, 7'd0, '0, '0, 1, 1, 7'd77);
    drive(0, 7'd127, '0, '0, 1, 1, 7'd3);
    drain();
  endtask

  task automatic test_masked_write();
    drive(1, 7'd5, 32'hFFFF_FFFF, 4'hF, 0, 0, 7'd0);
    drive(1, 7'd5, 32'hA5A5_1234, 4'b0101, 0, 0, 7'd0);
    drive(0, 7'd5, '0, '0, 1, 0, 7'd0);
    checks++;
    if (dout0_valid_a !== 1'b1 || dout0_a !== 32'hFFA5_FF34 || dout0_valid_b !== 1'b0) begin
      failures++;
      $display("FAIL lat1_read got=%h v=%b bv=%b exp=ffa5ff34 v=1 bv=0", dout0_a, dout0_valid_a, dout0_valid_b);
    end
    idle();
    tick();
    checks++;
    if (dout0_valid_b !== 1'b1 || dout0_b !== 32'hFFA5_FF34 || dout0_valid_a !== 1'b0 || dout0_a !== 32'hFFA5_FF34) begin
      failures++;
      $display("FAIL lat2_read_hold got=%h v=%b a=%h av=%b exp=ffa5ff34 v=1 hold av=0", dout0_b, dout0_valid_b, dout0_a, dout0_valid_a);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) drive(1, 7'(i), 32'h1000_0000 + 32'(i) * 32'h0101, 4'hF, 0, 0, 7'd0);
    drive(0, 7'd1, '0, '0, 1, 0, 7'd0);
    checks++;
    if (dout0_valid_b !== 1'b0) begin failures++; $display("FAIL b2b_v0 got=%b exp=0", dout0_valid_b); end
    drive(0, 7'd2, '0, '0, 1, 0, 7'd0);
    checks++;
    if (dout0_valid_b !== 1'b1) begin failures++; $display("FAIL b2b_v1 got=%b exp=1", dout0_valid_b); end
    drive(0, 7'd3, '0, '0, 1, 0, 7'd0);
    checks++;
    if (dout0_valid_b !== 1'b1) begin failures++; $display("FAIL b2b_v2 got=%b exp=1", dout0_valid_b); end
    idle();
    tick();
    checks++;
    if (dout0_valid_b !== 1'b1 || dout0_b !== 32'h1000_0303) begin
      failures++;
      $display("FAIL b2b_v3 got=%h v=%b exp=10000303 v=1", dout0_b, dout0_valid_b);
    end
    tick();
    checks++;
    if (dout0_valid_b !== 1'b0) begin failures++; $display("FAIL b2b_v4 got=%b exp=0", dout0_valid_b); end
    drain();
  endtask

  task automatic test_collision();
    drive(1, 7'd9, 32'h0, 4'hF, 0, 0, 7'd0);
    drive(1, 7'd9, 32'h1111_2222, 4'b1100, 0, 1, 7'd9);
    drain();
    checks++;
    if (dout1_a !== 32'h1111_0000 || dout1_b !== 32'h0 || cnt_a !== 16'd1 || cnt_b !== 2'd1) begin
      failures++;
      $display("FAIL collision got a=%h b=%h cnt=%0d/%0d exp a=11110000 b=0 cnt=1/1", dout1_a, dout1_b, cnt_a, cnt_b);
    end
    drive(0, 7'd9, '0, '0, 1, 1, 7'd9);
    drive(1, 7'd10, 32'h5, 4'hF, 0, 1, 7'd9);
    drain();
    checks++;
    if (cnt_a !== 16'd1 || cnt_b !== 2'd1) begin
      failures++;
      $display("FAIL no_count got=%0d/%0d exp=1/1", cnt_a, cnt_b);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 4; i++) drive(1, 7'(20 + i), 32'hCAFE_0000 | 32'(i), 4'(i + 1), 0, 1, 7'(20 + i));
    drain();
    checks++;
    if (cnt_a !== 16'd5 || cnt_b !== 2'd3) begin
      failures++;
      $display("FAIL saturate got=%0d/%0d exp=5/3", cnt_a, cnt_b);
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 7'd5, '0, '0, 1, 0, 7'd0);
    idle();
    @(negedge clk);
    #1;
    rstb = 1'b0;
    qb0.delete();
    #1;
    checks++;
    if ({dout0_a, dout0_b, dout1_a, cnt_a, cnt_b} !== '0 || {dout0_valid_a, dout0_valid_b, init_done_a, init_done_b} !== '0) begin
      failures++;
      $display("FAIL reset_inflight got=%h/%h v=%b init=%b exp=0", dout0_a, dout0_b, dout0_valid_b, init_done_b);
    end
    tick();
    rstb = 1'b1;
    repeat (60) tick();
    rstb = 1'b0;
    tick();
    rstb = 1'b1;
    for (int i = 0; i < 128; i++) ref_mem[i] = '0;
    repeat (127) tick();
    checks++;
    if (init_done_a !== 1'b0 || init_done_b !== 1'b0) begin
      failures++;
      $display("FAIL resweep_early got=%b%b exp=00", init_done_a, init_done_b);
    end
    tick();
    checks++;
    if (init_done_a !== 1'b1 || init_done_b !== 1'b1) begin
      failures++;
      $display("FAIL resweep_128 got=%b%b exp=11", init_done_a, init_done_b);
    end
    drive(0, 7'd5, '0, '0, 1, 1, 7'd9);
    drain();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) ref_mem[i] = '0;
    test_reset();
    test_cleared_read();
    test_masked_write();
    test_back_to_back();
    test_collision();
    test_saturate();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
